// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands LSB first,
// taking WIDTH cycles per addition behind a valid/ready handshake on both sides.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // working sum, filled from the MSB end
  logic [WIDTH-1:0]   sum_q, sum_d;   // published result, held until the next one completes
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               in_ready_q, out_valid_q;
  logic               fa_sum, fa_carry, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Single full-adder cell on the current LSBs and the carry flop.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit = (cnt_q == CntW'(WIDTH - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d = fa_carry;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          sum_d   = acc_d;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == StIdle);
      out_valid_q <= (state_d == StDone);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed/random, WIDTH=4 exhaustive, WIDTH=1 corner.
// Checks ovf as well when built with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4, ovf1;
`endif

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // Reference: plain integer addition; bit w of the total is the carry out.
  function automatic int unsigned ref_total(input int unsigned x, y, c);
    return x + y + c;
  endfunction

  // Reference: signed overflow means the true signed sum is out of the w-bit range.
  function automatic logic ref_ovf(input int w, input int unsigned x, y, c);
    int sx, sy, t;
    sx = (x >= (1 << (w - 1))) ? int'(x) - (1 << w) : int'(x);
    sy = (y >= (1 << (w - 1))) ? int'(y) - (1 << w) : int'(y);
    t  = sx + sy + int'(c);
    return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8: rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
               in_ready8, out_valid8, sum8, cout8);
    end
    n_cmp++;
    if ({in_ready4, out_valid4, sum4, cout4, in_ready1, out_valid1, sum1, cout1} !==
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset4_1: w4 rdy=%b vld=%b sum=%h cout=%b w1 rdy=%b vld=%b sum=%b cout=%b",
               in_ready4, out_valid4, sum4, cout4, in_ready1, out_valid1, sum1, cout1);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if ({ovf8, ovf4, ovf1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b%b%b want 000", ovf8, ovf4, ovf1);
    end
`endif
  endtask

  // One WIDTH=8 operation with junk on ignored inputs, a stall of 'hold' cycles in DONE.
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input int hold, input string tag);
    int unsigned t;
    logic [7:0]  es;
    logic        ec;
    logic        stable;
    t  = ref_total(x, y, c);
    es = t[7:0];
    ec = t[8];
    n_cmp++;
    if (in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before issue: got %b want 1", tag, in_ready8);
    end
    a8 = x; b8 = y; cin8 = c; in_valid8 = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      in_valid8  = 1'($urandom);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      cin8       = 1'($urandom);
      out_ready8 = 1'($urandom);
      tick();
      if (i < 8) begin
        n_cmp++;
        if ({in_ready8, out_valid8} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s run cycle %0d: rdy=%b vld=%b want 0 0", tag, i, in_ready8, out_valid8);
        end
      end
    end
    n_cmp++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b0, 1'b1, es, ec}) begin
      n_fail++;
      $display("FAIL %s result: rdy=%b vld=%b sum=%h cout=%b want 0 1 %h %b",
               tag, in_ready8, out_valid8, sum8, cout8, es, ec);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf8 !== ref_ovf(8, x, y, c)) begin
      n_fail++;
      $display("FAIL %s ovf: got %b want %b", tag, ovf8, ref_ovf(8, x, y, c));
    end
`endif
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      out_ready8 = 1'b0;
      in_valid8  = 1'($urandom);
      a8         = 8'($urandom);
      tick();
      if ({out_valid8, in_ready8, sum8, cout8} !== {1'b1, 1'b0, es, ec}) stable = 1'b0;
    end
    if (hold > 0) begin
      n_cmp++;
      if (!stable) begin
        n_fail++;
        $display("FAIL %s stall: vld=%b sum=%h cout=%b want 1 %h %b held",
                 tag, out_valid8, sum8, cout8, es, ec);
      end
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    n_cmp++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, es, ec}) begin
      n_fail++;
      $display("FAIL %s after accept: rdy=%b vld=%b sum=%h cout=%b want 1 0 %h %b",
               tag, in_ready8, out_valid8, sum8, cout8, es, ec);
    end
  endtask

  task automatic test_directed;
    run_op8(8'h03, 8'h05, 1'b0, 0, "add_3_5");
    run_op8(8'hFF, 8'h01, 1'b0, 1, "add_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, 0, "add_ff_ff_c");
    run_op8(8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
    run_op8(8'h80, 8'h80, 1'b0, 0, "add_80_80");
  endtask

  task automatic test_stall;
    run_op8(8'h5A, 8'hC3, 1'b1, 5, "stall5");
  endtask

  task automatic test_random8;
    for (int k = 0; k < 24; k++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand8");
  endtask

  task automatic test_back_to_back;
    run_op8(8'h12, 8'h34, 1'b0, 0, "b2b_0");
    run_op8(8'hF0, 8'h0F, 1'b1, 0, "b2b_1");
    run_op8(8'h00, 8'h00, 1'b0, 0, "b2b_2");
  endtask

  task automatic test_reset_run;
    logic quiet;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_run: rdy=%b vld=%b sum=%h cout=%b want 1 0 00 0",
               in_ready8, out_valid8, sum8, cout8);
    end
    quiet = 1'b1;
    repeat (12) begin
      tick();
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_run_quiet: vld=%b rdy=%b want 0 1 throughout", out_valid8, in_ready8);
    end
    // Reset in DONE with out_ready low discards the pending result.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready8, out_valid8, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_done: rdy=%b vld=%b sum=%h cout=%b want 1 0 00 0",
               in_ready8, out_valid8, sum8, cout8);
    end
    run_op8(8'h21, 8'h43, 1'b1, 0, "after_reset");
  endtask

  task automatic test_reset_priority;
    rst = 1'b1; in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    tick();
    rst = 1'b0; in_valid8 = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready8, out_valid8} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_priority: rdy=%b vld=%b want 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_exhaustive4;
    int          lat;
    int unsigned t;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          lat = 0;
          while (in_ready4 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
          end
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); in_valid4 = 1'b1;
          tick();
          in_valid4 = 1'b0;
          lat = 0;
          while (out_valid4 !== 1'b1 && lat < 12) begin
            out_ready4 = 1'($urandom);
            tick();
            lat++;
          end
          t = ref_total(x, y, c);
          n_cmp++;
          if (lat != 4 || {cout4, sum4} !== t[4:0]) begin
            n_fail++;
            $display("FAIL exh4 %0d+%0d+%0d: lat=%0d cout=%b sum=%h want lat=4 cout=%b sum=%h",
                     x, y, c, lat, cout4, sum4, t[4], t[3:0]);
          end
`ifdef SERIAL_ADDER_OVF_EN
          n_cmp++;
          if (ovf4 !== ref_ovf(4, x, y, c)) begin
            n_fail++;
            $display("FAIL exh4_ovf %0d+%0d+%0d: got %b want %b", x, y, c, ovf4,
                     ref_ovf(4, x, y, c));
          end
`endif
          out_ready4 = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          out_ready4 = 1'b1;
          tick();
          out_ready4 = 1'b0;
        end
      end
    end
  endtask

  task automatic test_width1;
    int          lat;
    int unsigned x, y, c, t;
    for (int k = 0; k < 8; k++) begin
      x = $urandom_range(0, 1); y = $urandom_range(0, 1); c = $urandom_range(0, 1);
      a1 = 1'(x); b1 = 1'(y); cin1 = 1'(c); in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 6) begin
        tick();
        lat++;
      end
      t = ref_total(x, y, c);
      n_cmp++;
      if (lat != 1 || {cout1, sum1} !== t[1:0]) begin
        n_fail++;
        $display("FAIL width1 %0d+%0d+%0d: lat=%0d cout=%b sum=%b want lat=1 cout=%b sum=%b",
                 x, y, c, lat, cout1, sum1, t[1], t[0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++;
      if (ovf1 !== ref_ovf(1, x, y, c)) begin
        n_fail++;
        $display("FAIL width1_ovf: got %b want %b", ovf1, ref_ovf(1, x, y, c));
      end
`endif
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random8();
    test_reset_run();
    test_reset_priority();
    test_exhaustive4();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/sum width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for bit 0.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL add bit-serially, LSB first: one 1-bit full-adder cell (sum = x^y^c, carry = majority(x,y,c)) plus one carry flip-flop.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge -> capture a, b into shift registers, carry register <= cin, bit counter <= 0, go RUN.
REQ-016 RUN: in_ready=0; each cycle adds current LSBs plus carry, shifts the sum bit in at the MSB of the sum register, updates carry, increments counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 go DONE.
REQ-018 Latency: acceptance at edge T -> out_valid=1 from edge T+WIDTH; minimum issue interval WIDTH+2 cycles.
REQ-019 DONE: out_valid=1, in_ready=0; sum, cout (and ovf) SHALL be held stable until out_ready=1 at an edge, then go IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; in_valid, a, b, cin SHALL be ignored outside IDLE.
REQ-021 sum/cout SHALL keep the last result after leaving DONE until the next result completes.
REQ-022 WIDTH=1 SHALL work: a single RUN cycle.
REQ-023 Counter width SHALL be $clog2(WIDTH+1); no wrap within a valid operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry and counter = 0, in any state.
REQ-025 Reset mid-RUN or mid-DONE SHALL discard the operation; no out_valid pulse follows.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: extra port ovf  output  1 = signed overflow (carry into bit WIDTH-1 XOR cout), registered, valid and held with sum.
REQ-028 Without SERIAL_ADDER_OVF_EN: no ovf port, no carry-into-MSB register; all other behaviour identical.

Verification
REQ-029 WIDTH=8, a=0x03, b=0x05, cin=0 accepted at edge T -> out_valid at T+8, sum=0x08, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 out_ready held low 5 cycles in DONE -> out_valid, sum, cout stable all 5 cycles; in_valid pulses during RUN/DONE ignored.
REQ-032 rst asserted at 4th RUN cycle -> next edge IDLE, in_ready=1, sum=0; no out_valid until a new operation.
REQ-033 OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 Exhaustive WIDTH=4, all a, b, cin, random out_ready -> sum/cout match a+b+cin per issue.
